// File: rtl/booth_divider_seq.sv
// Sequential signed divider: restoring, one quotient bit per cycle on operand
// magnitudes, with sign fix-up, divide-by-zero bypass and a start/done handshake.
module booth_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE_C     = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] a_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [WIDTH:0]   a_shift_s;
  logic [WIDTH:0]   diff_s;

  // Two's-complement negation, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction

  // The partial remainder stays below M, so it fits WIDTH bits at rest; the
  // extra bit exists only across the shift and trial subtraction.
  always_comb begin
    a_shift_s = {a_r, q_r[WIDTH-1]};
    diff_s    = a_shift_s - {1'b0, m_r};
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (divisor == ZERO_W) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_ITER) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      q_r         <= ZERO_W;
      m_r         <= ZERO_W;
      a_r         <= ZERO_W;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient    <= ZERO_W;
      remainder   <= ZERO_W;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_r <= state_s;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (divisor == ZERO_W) begin
              quotient    <= ONES_W;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              q_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg_r <= dividend[WIDTH-1];
              q_r     <= magnitude(dividend);
              m_r     <= magnitude(divisor);
              a_r     <= ZERO_W;
              count_r <= {CW{1'b0}};
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          // A negative trial difference restores A and shifts in a 0.
          if (diff_s[WIDTH]) begin
            a_r <= a_shift_s[WIDTH-1:0];
          end else begin
            a_r <= diff_s[WIDTH-1:0];
          end
          q_r     <= {q_r[WIDTH-2:0], ~diff_s[WIDTH]};
          count_r <= count_r + ONE_C;
        end
        FIX: begin
          quotient    <= q_neg_r ? negate(q_r) : q_r;
          remainder   <= r_neg_r ? negate(a_r) : a_r;
          div_by_zero <= 1'b0;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed self-checking bench for booth_divider_seq: reset, signs, divide by
// zero, corner values, start while busy and reset mid-operation.
module tb_booth_divider_seq;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int tests_run = 0;
  int failed    = 0;

  booth_divider_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one operation from #1 after an edge; reports latency in cycles
  // after acceptance (-1 on timeout), results, busy-protocol violations and
  // whether done stayed high in the following cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q,
                        output logic [31:0] r, output logic z,
                        output int busy_bad, output logic done_twice);
    logic exp_busy;
    exp_busy   = (b != 32'd0);
    lat        = -1;
    q          = 32'hDEAD_BEEF;
    r          = 32'hDEAD_BEEF;
    z          = 1'bx;
    busy_bad   = 0;
    done_twice = 1'b0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock); #1;
    start    = 1'b0;
    dividend = 32'h5A5A_5A5A;
    divisor  = 32'h0000_0000;
    if (!done && busy !== exp_busy) busy_bad++;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        lat = n;
        q   = quotient;
        r   = remainder;
        z   = div_by_zero;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== exp_busy) busy_bad++;
    end
    if (lat != -1) begin
      @(posedge clock); #1;
      done_twice = (done !== 1'b0);
    end
  endtask

  task automatic test_reset();
    int lat, bb; logic [31:0] q, r; logic z, d2;
    resetn = 1'b0;
    start  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
      failed++;
      $display("FAIL reset_state: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    resetn = 1'b1;
    run_op(32'd100, 32'd7, lat, q, r, z, bb, d2);
    tests_run++;
    if (lat != 34 || q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      failed++;
      $display("FAIL first_op_100_7: lat=%0d q=%h r=%h dbz=%b, required lat=34 q=e r=2 dbz=0",
               lat, q, r, z);
    end
    tests_run++;
    if (bb != 0 || d2) begin
      failed++;
      $display("FAIL first_op_handshake: busy_bad=%0d done_twice=%b, required 0 0", bb, d2);
    end
  endtask

  task automatic test_signs();
    logic [31:0] va [3] = '{32'hFFFF_FF9C, 32'd100,      32'hFFFF_FF9C};
    logic [31:0] vb [3] = '{32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] eq [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] er [3] = '{32'hFFFF_FFFE, 32'd2,         32'hFFFF_FFFE};
    int lat, bb; logic [31:0] q, r; logic z, d2;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, q, r, z, bb, d2);
      tests_run++;
      if (lat != 34 || q !== eq[i] || r !== er[i] || z !== 1'b0 || bb != 0) begin
        failed++;
        $display("FAIL signs_%0d: lat=%0d q=%h r=%h dbz=%b busy_bad=%0d, required lat=34 q=%h r=%h dbz=0",
                 i, lat, q, r, z, bb, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bb; logic [31:0] q, r; logic z, d2;
    run_op(32'd7, 32'd0, lat, q, r, z, bb, d2);
    tests_run++;
    if (lat != 1 || z !== 1'b1) begin
      failed++;
      $display("FAIL dbz_timing: lat=%0d dbz=%b, required lat=1 dbz=1", lat, z);
    end
    tests_run++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd7) begin
      failed++;
      $display("FAIL dbz_values: q=%h r=%h, required q=ffffffff r=7", q, r);
    end
    tests_run++;
    if (bb != 0 || d2) begin
      failed++;
      $display("FAIL dbz_busy: busy_bad=%0d done_twice=%b, required 0 0", bb, d2);
    end
    run_op(32'd9, 32'd3, lat, q, r, z, bb, d2);
    tests_run++;
    if (lat != 34 || q !== 32'd3 || r !== 32'd0 || z !== 1'b0) begin
      failed++;
      $display("FAIL after_dbz_9_3: lat=%0d q=%h r=%h dbz=%b, required lat=34 q=3 r=0 dbz=0",
               lat, q, r, z);
    end
  endtask

  task automatic test_corners();
    logic [31:0] va [4] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'h7FFF_FFFF};
    logic [31:0] vb [4] = '{32'hFFFF_FFFF, 32'd1,         32'd9, 32'h7FFF_FFFF};
    logic [31:0] eq [4] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1};
    logic [31:0] er [4] = '{32'd0,         32'd0,         32'd5, 32'd0};
    int lat, bb; logic [31:0] q, r; logic z, d2;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, q, r, z, bb, d2);
      tests_run++;
      if (lat != 34 || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
        failed++;
        $display("FAIL corner_%0d: lat=%0d q=%h r=%h dbz=%b, required lat=34 q=%h r=%h dbz=0",
                 i, lat, q, r, z, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat = -1;
    int ndone = 0;
    logic [31:0] q = 32'hDEAD_BEEF;
    logic [31:0] r = 32'hDEAD_BEEF;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      start = (n == 5);
      if (n == 5) begin dividend = 32'd1; divisor = 32'd1; end
      @(posedge clock); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (lat == -1) begin lat = n; q = quotient; r = remainder; end
      end
    end
    tests_run++;
    if (lat != 34 || q !== 32'd100 || r !== 32'd0) begin
      failed++;
      $display("FAIL start_while_busy_result: lat=%0d q=%h r=%h, required lat=34 q=64 r=0",
               lat, q, r);
    end
    tests_run++;
    if (ndone != 1) begin
      failed++;
      $display("FAIL start_while_busy_done_count: got %0d, required 1", ndone);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bb, ndone; logic [31:0] q, r; logic z, d2;
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    tests_run++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
      failed++;
      $display("FAIL mid_reset_state: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone != 0) begin
      failed++;
      $display("FAIL mid_reset_no_done: saw %0d busy/done cycles, required 0", ndone);
    end
    run_op(32'd50, 32'd5, lat, q, r, z, bb, d2);
    tests_run++;
    if (lat != 34 || q !== 32'd10 || r !== 32'd0 || bb != 0) begin
      failed++;
      $display("FAIL after_mid_reset_50_5: lat=%0d q=%h r=%h busy_bad=%0d, required lat=34 q=a r=0 busy_bad=0",
               lat, q, r, bb);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    test_reset();
    test_signs();
    test_div_by_zero();
    test_corners();
    test_start_while_busy();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
